// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: FSM states, register offsets,
// channel count, AXI response code and the pending-priority helper.
package tick_sched_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_PEND    = 8'h04;
  localparam logic [7:0] OFF_ACTIVE  = 8'h08;
  localparam logic [7:0] OFF_OVR     = 8'h0C;
  localparam logic [7:0] OFF_RELOAD0 = 8'h10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_RESP
  } r_state_t;

  // {valid, index} of the lowest set bit, all zero when none is set
  function automatic logic [2:0] lowest_set(
    input logic [NUM_CH-1:0] v
  );
    logic [2:0] r;
    r = 3'b000;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sched_chan.sv
// One tick-divider channel: down-counter that fires on an enabled tick
// while at zero, then reloads; a register write loads it directly.
import tick_sched_pkg::*;

module tick_sched_chan #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] reload_i,
  output logic         fire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign fire_o = tick_i & en_i & (cnt_q == '0);

  // a register load beats the tick decrement of the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && en_i) begin
      cnt_d = fire_o ? reload_i : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(15);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Four-channel tick divider with AXI4-Lite registers and a level irq.
// Define TICK_SCHED_OVERRUN_EN to build the sticky overrun flags (OVR).
import tick_sched_pkg::*;

module tick_scheduler #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int RELOAD_W           = 16
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          tick_in,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          irq
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  w_state_t             w_state_q;
  logic [AW-1:0]        aw_addr_q;
  logic                 awready_q;
  logic                 wready_q;
  logic                 bvalid_q;
  r_state_t             r_state_q;
  logic [AW-1:0]        ar_addr_q;
  logic                 arready_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;

  logic                 tick_q;
  logic                 tick_ev;
  logic                 gen_q, gen_d;
  logic [NUM_CH-1:0]    chen_q, chen_d;
  logic [NUM_CH-1:0]    imask_q, imask_d;
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic                 irq_q, irq_d;
  logic [RELOAD_W-1:0]  reload_q [NUM_CH];
  logic [RELOAD_W-1:0]  reload_d [NUM_CH];
  logic [NUM_CH-1:0]    fire;
  logic [NUM_CH-1:0]    ovr;

  logic                 wr_en;
  logic [AW-1:0]        wr_al;
  logic [AW-1:0]        rd_al;
  logic [NUM_CH-1:0]    wr_reload;
  logic [NUM_CH-1:0]    w1c_pend;
  logic [2:0]           act;
  logic [31:0]          rd_mux;
  logic                 unused_in;

  assign unused_in = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                       s_axi_wdata, aw_addr_q[1:0], ar_addr_q[1:0]};

  assign tick_ev  = tick_in & ~tick_q;
  assign wr_en    = (w_state_q == W_DATA) & wready_q & s_axi_wvalid;
  assign wr_al    = {aw_addr_q[AW-1:2], 2'b00};
  assign rd_al    = {ar_addr_q[AW-1:2], 2'b00};
  assign w1c_pend = (wr_en && wr_al == AW'(OFF_PEND)) ?
                    s_axi_wdata[NUM_CH-1:0] : '0;
  assign act      = lowest_set(pend_q & imask_q);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    assign wr_reload[n] = wr_en &&
      (wr_al == AW'(int'(OFF_RELOAD0) + 4 * n));

    tick_sched_chan #(
      .W          (RELOAD_W)
    ) u_chan (
      .clk        (s_axi_aclk),
      .rst_n      (s_axi_aresetn),
      .tick_i     (tick_ev),
      .en_i       (gen_q & chen_q[n]),
      .load_i     (wr_reload[n]),
      .load_val_i (s_axi_wdata[RELOAD_W-1:0]),
      .reload_i   (reload_q[n]),
      .fire_o     (fire[n])
    );
  end

  always_comb begin
    gen_d   = gen_q;
    chen_d  = chen_q;
    imask_d = imask_q;
    if (wr_en && wr_al == AW'(OFF_CTRL)) begin
      gen_d   = s_axi_wdata[0];
      chen_d  = s_axi_wdata[7:4];
      imask_d = s_axi_wdata[11:8];
    end
    // a firing channel re-sets its bit even when cleared this cycle
    pend_d = (pend_q & ~w1c_pend) | fire;
    irq_d  = |(pend_q & imask_q);
    for (int n = 0; n < NUM_CH; n++) begin
      reload_d[n] = wr_reload[n] ?
                    s_axi_wdata[RELOAD_W-1:0] : reload_q[n];
    end
  end

`ifdef TICK_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [NUM_CH-1:0] w1c_ovr;

  assign w1c_ovr = (wr_en && wr_al == AW'(OFF_OVR)) ?
                   s_axi_wdata[NUM_CH-1:0] : '0;
  assign ovr     = ovr_q;

  always_comb begin
    ovr_d = (ovr_q & ~w1c_ovr) | (fire & pend_q);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end
`else
  assign ovr = '0;
`endif

  always_comb begin
    rd_mux = '0;
    if (rd_al == AW'(OFF_CTRL)) begin
      rd_mux = {20'b0, imask_q, chen_q, 3'b000, gen_q};
    end else if (rd_al == AW'(OFF_PEND)) begin
      rd_mux = 32'(pend_q);
    end else if (rd_al == AW'(OFF_ACTIVE)) begin
      rd_mux = 32'({act[2], 2'b00, act[1:0]});
    end else if (rd_al == AW'(OFF_OVR)) begin
      rd_mux = 32'(ovr);
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (rd_al == AW'(int'(OFF_RELOAD0) + 4 * n)) begin
          rd_mux = 32'(reload_q[n]);
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tick_q  <= 1'b0;
      gen_q   <= 1'b0;
      chen_q  <= '0;
      imask_q <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        reload_q[n] <= RELOAD_W'(15);
      end
    end else begin
      tick_q  <= tick_in;
      gen_q   <= gen_d;
      chen_q  <= chen_d;
      imask_q <= imask_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      for (int n = 0; n < NUM_CH; n++) begin
        reload_q[n] <= reload_d[n];
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          awready_q <= 1'b0;
          if (s_axi_wvalid && wready_q) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            arready_q <= 1'b1;
            ar_addr_q <= s_axi_araddr;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          arready_q <= 1'b0;
          rdata_q   <= rd_mux;
          rvalid_q  <= 1'b1;
          r_state_q <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign irq           = irq_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: vector table, corner sequences and a
// randomized run checked against an event-level reference model.
module tb_tick_scheduler;

`ifdef TICK_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [4:0]  awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 1'b0, arready;
  logic [4:0]  araddr = '0;
  logic [31:0] rdata;
  logic        rvalid, rready = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_scheduler dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .tick_in       (tick_in),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'b000),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (4'hF),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'b000),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .irq           (irq)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not complete in budget", name);
  endtask

  // reference model: counts tick events since the last (re)load
  int       m_reload [4];
  int       m_age [4];
  bit       m_gen;
  bit [3:0] m_chen, m_imask, m_pend, m_ovr;

  function automatic void m_reset();
    for (int n = 0; n < 4; n++) begin
      m_reload[n] = 15;
      m_age[n] = 0;
    end
    m_gen = 0; m_chen = 0; m_imask = 0; m_pend = 0; m_ovr = 0;
  endfunction

  function automatic void m_tick();
    for (int n = 0; n < 4; n++) begin
      if (m_gen && m_chen[n]) begin
        m_age[n]++;
        if (m_age[n] > m_reload[n]) begin
          if (OVR_EN && m_pend[n]) m_ovr[n] = 1'b1;
          m_pend[n] = 1'b1;
          m_age[n] = 0;
        end
      end
    end
  endfunction

  function automatic void m_write(input logic [4:0] a,
                                  input logic [31:0] d);
    case (a)
      5'h00: begin
        m_gen = d[0]; m_chen = d[7:4]; m_imask = d[11:8];
      end
      5'h04: m_pend = m_pend & ~d[3:0];
      5'h0C: m_ovr = m_ovr & ~d[3:0];
      5'h10, 5'h14, 5'h18, 5'h1C: begin
        m_reload[a[3:2]] = int'(d[15:0]);
        m_age[a[3:2]] = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [3:0] pm;
    int idx;
    pm = m_pend & m_imask;
    idx = -1;
    for (int i = 3; i >= 0; i--) if (pm[i]) idx = i;
    case (a)
      5'h00: return {20'b0, m_imask, m_chen, 3'b000, m_gen};
      5'h04: return {28'b0, m_pend};
      5'h08: return (idx < 0) ? 32'h0 : (32'h10 | 32'(idx));
      5'h0C: return {28'b0, m_ovr};
      default: return 32'(m_reload[a[3:2]]);
    endcase
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input bit tick_on_w, output logic [1:0] resp);
    bit done = 0;
    resp = 2'b11;
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wvalid = 1; bready = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      bit ha, hw, hb;
      @(negedge clk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      hb = bvalid && bready;
      if (hw && tick_on_w) tick_in = 1;
      if (hb) resp = bresp;
      @(posedge clk); #1;
      if (ha) awvalid = 0;
      if (hw) wvalid = 0;
      if (hw && tick_on_w) tick_in = 0;
      if (hb) begin bready = 0; done = 1; end
    end
    if (!done) begin
      timeout("axi_write");
      awvalid = 0; wvalid = 0; bready = 0; tick_in = 0;
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
    bit done = 0, seen = 0, stable = 1;
    int held = 0;
    logic [31:0] first;
    d = 32'hDEAD_BEEF; resp = 2'b11; first = '0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = (hold == 0);
    for (int c = 0; c < 40 && !done; c++) begin
      bit ha, hr, rv;
      @(negedge clk);
      ha = arvalid && arready;
      rv = rvalid;
      hr = rv && rready;
      if (rv) begin
        if (!seen) begin first = rdata; seen = 1; end
        else if (rdata !== first) stable = 0;
      end
      if (hr) begin d = rdata; resp = rresp; end
      @(posedge clk); #1;
      if (ha) arvalid = 0;
      if (hr) begin rready = 0; done = 1; end
      else if (rv) begin
        held++;
        if (held >= hold) rready = 1;
      end
    end
    if (!done) begin
      timeout("axi_read");
      arvalid = 0; rready = 0;
    end else if (hold > 0) begin
      check($sformatf("rhold_stable_%02h", a), {31'b0, stable}, 32'h1);
      check($sformatf("rhold_cycles_%02h", a), 32'(held), 32'(hold));
    end
  endtask

  task automatic do_tick(input int hi);
    @(negedge clk); tick_in = 1;
    repeat (hi) @(negedge clk);
    tick_in = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; tick_in = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    m_reset();
    @(negedge clk);
  endtask

  task automatic wr_chk(input logic [4:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 1'b0, r);
    check($sformatf("bresp_%02h", a), 32'(r), 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, 0, d, r);
    check(name, d, exp);
  endtask

  typedef enum {OP_WR, OP_RD, OP_TICK, OP_IRQ, OP_RST} op_e;
  typedef struct {
    op_e         op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(op_e op, logic [4:0] a,
                              logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    logic [1:0]  r;
    bit          got;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {25'b0, awready, wready, bvalid, arready, rvalid, irq,
           |rdata},
          32'h0);
    rst_n = 1;
    m_reset();
    @(negedge clk);

    add(OP_RD,   5'h10, 0, 32'h0000_000F);
    add(OP_RD,   5'h00, 0, 32'h0);
    add(OP_IRQ,  5'h00, 0, 32'h0);
    add(OP_RD,   5'h04, 0, 32'h0);
    add(OP_RD,   5'h08, 0, 32'h0);
    add(OP_RD,   5'h0C, 0, 32'h0);
    add(OP_WR,   5'h14, 32'h2, 0);
    add(OP_WR,   5'h00, 32'h221, 0);
    add(OP_TICK, 5'h00, 0, 0);
    add(OP_TICK, 5'h00, 0, 0);
    add(OP_RD,   5'h04, 0, 32'h0);
    add(OP_IRQ,  5'h00, 0, 32'h0);
    add(OP_TICK, 5'h00, 0, 0);
    add(OP_RD,   5'h04, 0, 32'h2);
    add(OP_IRQ,  5'h00, 0, 32'h1);
    add(OP_RD,   5'h08, 0, 32'h11);
    add(OP_RD,   5'h00, 0, 32'h221);
    add(OP_RST,  5'h00, 0, 0);
    add(OP_WR,   5'h10, 32'h0, 0);
    add(OP_WR,   5'h18, 32'h0, 0);
    add(OP_WR,   5'h00, 32'h551, 0);
    add(OP_TICK, 5'h00, 0, 0);
    add(OP_RD,   5'h04, 0, 32'h5);
    add(OP_RD,   5'h08, 0, 32'h10);
    add(OP_WR,   5'h04, 32'h1, 0);
    add(OP_RD,   5'h08, 0, 32'h12);
    add(OP_RD,   5'h04, 0, 32'h4);
    add(OP_IRQ,  5'h00, 0, 32'h1);
    add(OP_WR,   5'h08, 32'hFFFF_FFFF, 0);
    add(OP_RD,   5'h08, 0, 32'h12);
    add(OP_WR,   5'h00, 32'hFFFF_FFFF, 0);
    add(OP_RD,   5'h00, 0, 32'hFF1);
    add(OP_WR,   5'h04, 32'hF, 0);
    add(OP_RD,   5'h04, 0, 32'h0);
    add(OP_IRQ,  5'h00, 0, 32'h0);
    add(OP_WR,   5'h1C, 32'hABCD_1234, 0);
    add(OP_RD,   5'h1C, 0, 32'h1234);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_WR:   wr_chk(tbl[i].addr, tbl[i].data);
        OP_RD:   rd_chk($sformatf("vec%0d_rd_%02h", i, tbl[i].addr),
                        tbl[i].addr, tbl[i].exp);
        OP_TICK: do_tick(1);
        OP_IRQ:  check($sformatf("vec%0d_irq", i), {31'b0, irq},
                       tbl[i].exp);
        default: apply_reset();
      endcase
    end

    // W1C of PEND[0] landing on the same edge channel 0 fires
    apply_reset();
    wr_chk(5'h10, 32'h0);
    wr_chk(5'h00, 32'h011);
    do_tick(1);
    rd_chk("w1c_pre_pend", 5'h04, 32'h1);
    axi_write(5'h04, 32'h1, 1'b1, r);
    rd_chk("w1c_vs_fire", 5'h04, 32'h1);
    wr_chk(5'h04, 32'h1);
    rd_chk("w1c_plain", 5'h04, 32'h0);

    // reload write overrides a coincident tick decrement
    apply_reset();
    wr_chk(5'h14, 32'h5);
    wr_chk(5'h00, 32'h221);
    axi_write(5'h14, 32'h1, 1'b1, r);
    do_tick(1);
    rd_chk("load_vs_tick_1", 5'h04, 32'h0);
    do_tick(1);
    rd_chk("load_vs_tick_2", 5'h04, 32'h2);

    // tick held high for several cycles is a single event
    apply_reset();
    wr_chk(5'h18, 32'h1);
    wr_chk(5'h00, 32'h441);
    do_tick(4);
    rd_chk("long_tick_1", 5'h04, 32'h0);
    do_tick(1);
    rd_chk("long_tick_2", 5'h04, 32'h4);
    check("long_tick_irq", {31'b0, irq}, 32'h1);

    // overrun flag
    apply_reset();
    wr_chk(5'h1C, 32'h0);
    wr_chk(5'h00, 32'h081);
    do_tick(1);
    do_tick(1);
    rd_chk("ovr_set", 5'h0C, OVR_EN ? 32'h8 : 32'h0);
    rd_chk("ovr_pend", 5'h04, 32'h8);
    wr_chk(5'h0C, 32'h8);
    rd_chk("ovr_clr", 5'h0C, 32'h0);

    // read-only target write, reads with rready held low
    apply_reset();
    wr_chk(5'h08, 32'hFFFF_FFFF);
    axi_read(5'h08, 5, d, r);
    check("hold_rd_08", d, 32'h0);
    check("hold_rresp_08", 32'(r), 32'h0);
    axi_read(5'h14, 5, d, r);
    check("hold_rd_14", d, 32'hF);

    // reset in the middle of a write
    @(negedge clk);
    awaddr = 5'h00; wdata = 32'h1; awvalid = 1; bready = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = awready;
    end
    if (!got) timeout("abort_wr_awready");
    rst_n = 0; awvalid = 0;
    #1;
    check("abort_wr_async", {30'b0, awready, wready}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    wvalid = 1;
    got = 0;
    repeat (4) begin
      @(negedge clk);
      got = got | bvalid;
    end
    wvalid = 0; bready = 0;
    check("abort_wr_no_b", {31'b0, got}, 32'h0);
    rd_chk("abort_wr_ctrl", 5'h00, 32'h0);

    // reset in the middle of a read
    @(negedge clk);
    araddr = 5'h10; arvalid = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = arready;
    end
    if (!got) timeout("abort_rd_arready");
    rst_n = 0; arvalid = 0;
    @(negedge clk);
    rst_n = 1;
    rready = 1;
    got = 0;
    repeat (4) begin
      @(negedge clk);
      got = got | rvalid;
    end
    rready = 0;
    check("abort_rd_no_r", {31'b0, got}, 32'h0);

    // randomized run against the event-level model
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      int          k;
      logic [4:0]  a;
      logic [31:0] v;
      k = $urandom_range(0, 9);
      if (k < 3) begin
        do_tick($urandom_range(1, 3));
        m_tick();
        check($sformatf("rnd%0d_irq_t", i), {31'b0, irq},
              {31'b0, |(m_pend & m_imask)});
      end else if (k < 6) begin
        v = $urandom;
        case ($urandom_range(0, 4))
          0: begin
            a = 5'h00;
            v[0] = ($urandom_range(0, 3) != 0);
          end
          1: a = 5'h04;
          2: a = 5'h0C;
          3: begin
            a = 5'(5'h10 + 4 * $urandom_range(0, 3));
            v = (v & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
          end
          default: a = 5'h08;
        endcase
        axi_write(a, v, 1'b0, r);
        m_write(a, v);
        check($sformatf("rnd%0d_bresp", i), 32'(r), 32'h0);
        check($sformatf("rnd%0d_irq_w", i), {31'b0, irq},
              {31'b0, |(m_pend & m_imask)});
      end else begin
        a = 5'(4 * $urandom_range(0, 7));
        axi_read(a, $urandom_range(0, 2), d, r);
        check($sformatf("rnd%0d_rd_%02h", i, a), d, m_read(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
